pipe_stage: RTL

Parametrised pipeline stage register, successor to the fixed-field ID/EX latch. It carries an opaque DW-bit payload between two pipeline stages using a valid/ready handshake instead of a global stall vector. A 2-entry skid buffer gives full throughput with a registered `in_ready`. Empty slots present a configurable bubble (NOP) payload, and a `flush` input kills in-flight contents on branch redirect. The block is instantiated between each stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with a 2-entry skid buffer.
// The main register drives the outputs directly. The hidden skid register
// absorbs the one beat that arrives while downstream first stalls.
// Empty slots present BUBBLE. flush kills both entries.
// A saturating counter records the cycles in which downstream stalls a valid output.
module pipe_stage #(
    parameter int            DW     = 64,
    parameter logic [DW-1:0] BUBBLE = {DW{1'b0}},
    parameter int            SCW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [1:0]     occupancy,
    output logic [SCW-1:0] stall_cnt
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high. A producer holds valid and data stable until that edge. A
    // consumer may drive ready regardless of valid. in_ready is derived only
    // from registered state, so it never depends combinationally on out_ready.

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          s_valid;
    logic [DW-1:0] s_data;

    logic in_fire;
    logic out_fire;
    logic main_free;

    localparam logic [SCW-1:0] STALL_MAX = {SCW{1'b1}};

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = m_valid && out_ready;
    // Main can take a new value when it is empty or its current beat is leaving.
    assign main_free = !m_valid || out_fire;

    // Main and skid registers: reset beats flush, and flush beats the handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            m_valid <= 1'b0;
            m_data  <= BUBBLE;
            s_valid <= 1'b0;
            s_data  <= BUBBLE;
        end else if (main_free) begin
            if (s_valid) begin
                // Drain: the skid is full only when in_ready was low, so no input beat competes.
                m_valid <= 1'b1;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
            end else begin
                // Reload BUBBLE so a killed or consumed payload never stays visible.
                m_valid <= 1'b0;
                m_data  <= BUBBLE;
            end
        end else if (in_fire) begin
            // Main is held by backpressure, so the accepted beat parks in the skid.
            s_valid <= 1'b1;
            s_data  <= in_data;
        end
    end

    // Stall statistics: saturating; only reset clears it, and flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
